// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, a four-state
// count FSM and a maskable interrupt flag driving a CP0 hardware interrupt line.
module timer_dev (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_LOAD     = 2'd1;
    localparam logic [1:0] ST_CNT      = 2'd2;
    localparam logic [1:0] ST_INT      = 2'd3;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam logic [1:0] MODE_RELOAD = 2'b01;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [3:0]  ctrl_r;
    logic [3:0]  ctrl_nxt_s;
    logic [31:0] preset_r;
    logic [31:0] preset_nxt_s;
    logic [31:0] count_r;
    logic [31:0] count_nxt_s;
    logic        irq_flag_r;
    logic        irq_flag_nxt_s;

    logic        en_s;
    logic        auto_reload_s;
    logic        ctrl_we_s;
    logic        preset_we_s;
    logic        hw_clear_en_s;
    logic        irq_set_s;
    logic        irq_fsm_clear_s;

    // Modes 10 and 11 fall through to one-shot behaviour.
    assign en_s          = ctrl_r[0];
    assign auto_reload_s = (ctrl_r[2:1] == MODE_RELOAD);
    assign ctrl_we_s     = WE && (Addr == ADDR_CTRL);
    assign preset_we_s   = WE && (Addr == ADDR_PRESET);

    // Count FSM: next state, next COUNT and the flag/enable side effects.
    always_comb begin
        state_nxt_s     = state_r;
        count_nxt_s     = count_r;
        hw_clear_en_s   = 1'b0;
        irq_set_s       = 1'b0;
        irq_fsm_clear_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (en_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                count_nxt_s = preset_r;
                state_nxt_s = ST_CNT;
            end
            ST_CNT: begin
                if (!en_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (count_r <= 32'd1) begin
                    // Terminal count also covers PRESET = 0, so COUNT never wraps.
                    count_nxt_s = 32'd0;
                    irq_set_s   = 1'b1;
                    state_nxt_s = ST_INT;
                end else begin
                    count_nxt_s = count_r - 32'd1;
                end
            end
            ST_INT: begin
                if (auto_reload_s) begin
                    irq_fsm_clear_s = 1'b1;
                    if (en_s) begin
                        state_nxt_s = ST_LOAD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    hw_clear_en_s = 1'b1;
                    state_nxt_s   = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Register write merge: software CTRL writes beat the hardware En clear,
    // and a terminal-count set beats any clear of the interrupt flag.
    always_comb begin
        if (ctrl_we_s) begin
            ctrl_nxt_s = Din[3:0];
        end else if (hw_clear_en_s) begin
            ctrl_nxt_s = {ctrl_r[3:1], 1'b0};
        end else begin
            ctrl_nxt_s = ctrl_r;
        end

        if (preset_we_s) begin
            preset_nxt_s = Din;
        end else begin
            preset_nxt_s = preset_r;
        end

        if (irq_set_s) begin
            irq_flag_nxt_s = 1'b1;
        end else if (irq_fsm_clear_s) begin
            irq_flag_nxt_s = 1'b0;
        end else if (!auto_reload_s && (ctrl_we_s || preset_we_s)) begin
            irq_flag_nxt_s = 1'b0;
        end else begin
            irq_flag_nxt_s = irq_flag_r;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r    <= ST_IDLE;
            ctrl_r     <= 4'd0;
            preset_r   <= 32'd0;
            count_r    <= 32'd0;
            irq_flag_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ctrl_r     <= ctrl_nxt_s;
            preset_r   <= preset_nxt_s;
            count_r    <= count_nxt_s;
            irq_flag_r <= irq_flag_nxt_s;
        end
    end

    // Zero-latency read mux for the bridge read path.
    always_comb begin
        case (Addr)
            ADDR_CTRL:   Dout = {28'd0, ctrl_r};
            ADDR_PRESET: Dout = preset_r;
            ADDR_COUNT:  Dout = count_r;
            default:     Dout = 32'd0;
        endcase
    end

    assign IRQ = irq_flag_r & ctrl_r[3];

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: a vector table for reset/one-shot/register
// behaviour plus hand-written sequences for reload, masking, freeze and reset.
module tb_timer_dev;

    logic        Clk;
    logic        Reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int errors;
    int checks;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    timer_dev dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 unit later.
    task automatic drive(input logic we_i, input logic [1:0] a, input logic [31:0] d);
        @(negedge Clk);
        WE   = we_i;
        Addr = a;
        Din  = d;
        #1;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        WE    = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            Addr = a[1:0];
            #1;
            check("reset_dout", Dout, 32'd0);
        end
        check("reset_irq", 32'(IRQ), 32'd0);
    endtask

    task automatic add_vec(input logic we_i, input logic [1:0] a, input logic [31:0] d,
                           input logic [31:0] ed, input logic ei);
        vec_t v;
        v.we = we_i;
        v.addr = a;
        v.din = d;
        v.exp_dout = ed;
        v.exp_irq = ei;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] exp_cnt_reload3(input int k);
        if (k < 2) begin
            return 32'd0;
        end else begin
            case ((k - 2) % 5)
                0: return 32'd3;
                1: return 32'd2;
                2: return 32'd1;
                default: return 32'd0;
            endcase
        end
    endfunction

    initial begin
        int found;
        errors = 0;
        checks = 0;
        Reset  = 1'b0;
        WE     = 1'b0;
        Addr   = 2'd0;
        Din    = 32'd0;

        // Each vector: Dout/IRQ reflect state before the edge that applies it.
        add_vec(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
        add_vec(1'b0, 2'd1, 32'd0, 32'd0, 1'b0);
        add_vec(1'b0, 2'd2, 32'd0, 32'd0, 1'b0);
        add_vec(1'b0, 2'd3, 32'd0, 32'd0, 1'b0);
        add_vec(1'b1, 2'd1, 32'd5, 32'd0, 1'b0);
        add_vec(1'b1, 2'd0, 32'h9, 32'd0, 1'b0);
        add_vec(1'b0, 2'd2, 32'd0, 32'd0, 1'b0);
        add_vec(1'b0, 2'd2, 32'd0, 32'd0, 1'b0);
        add_vec(1'b0, 2'd2, 32'd0, 32'd5, 1'b0);
        add_vec(1'b0, 2'd2, 32'd0, 32'd4, 1'b0);
        add_vec(1'b0, 2'd2, 32'd0, 32'd3, 1'b0);
        add_vec(1'b0, 2'd2, 32'd0, 32'd2, 1'b0);
        add_vec(1'b0, 2'd2, 32'd0, 32'd1, 1'b0);
        add_vec(1'b0, 2'd2, 32'd0, 32'd0, 1'b1);
        add_vec(1'b0, 2'd0, 32'd0, 32'h8, 1'b1);
        add_vec(1'b0, 2'd1, 32'd0, 32'd5, 1'b1);
        add_vec(1'b1, 2'd0, 32'd0, 32'h8, 1'b1);
        add_vec(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
        add_vec(1'b1, 2'd2, 32'h55, 32'd0, 1'b0);
        add_vec(1'b1, 2'd3, 32'h77, 32'd0, 1'b0);
        add_vec(1'b0, 2'd2, 32'd0, 32'd0, 1'b0);
        add_vec(1'b0, 2'd3, 32'd0, 32'd0, 1'b0);
        add_vec(1'b0, 2'd1, 32'd0, 32'd5, 1'b0);
        add_vec(1'b1, 2'd0, 32'hFFFF_FFF0, 32'd0, 1'b0);
        add_vec(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);

        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].din);
            checks++;
            if (Dout !== vecs[i].exp_dout) begin
                errors++;
                $display("FAIL vec%0d_dout: got %0h expected %0h", i, Dout, vecs[i].exp_dout);
            end
            checks++;
            if (IRQ !== vecs[i].exp_irq) begin
                errors++;
                $display("FAIL vec%0d_irq: got %0b expected %0b", i, IRQ, vecs[i].exp_irq);
            end
        end

        // Auto-reload, PRESET = 3: one-cycle pulses every 5 cycles.
        drive(1'b1, 2'd1, 32'd3);
        drive(1'b1, 2'd0, 32'hB);
        for (int k = 0; k < 22; k++) begin
            drive(1'b0, 2'd2, 32'd0);
            check("reload3_irq", 32'(IRQ), ((k > 0) && (k % 5 == 0)) ? 32'd1 : 32'd0);
            check("reload3_count", Dout, exp_cnt_reload3(k));
        end
        do_reset();

        // One-shot with IM = 0: flag set but masked; CTRL write clears it.
        drive(1'b1, 2'd1, 32'd2);
        drive(1'b1, 2'd0, 32'h1);
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 2'd0, 32'd0);
            check("mask_irq", 32'(IRQ), 32'd0);
            check("mask_ctrl", Dout, (k < 5) ? 32'h1 : 32'h0);
        end
        drive(1'b1, 2'd0, 32'h8);
        drive(1'b0, 2'd0, 32'd0);
        check("unmask_ctrl", Dout, 32'h8);
        check("unmask_irq", 32'(IRQ), 32'd0);
        drive(1'b0, 2'd0, 32'd0);
        check("unmask_irq2", 32'(IRQ), 32'd0);

        // One-shot, IM = 1, PRESET = 2: IRQ after edge 4, PRESET write drops it.
        drive(1'b1, 2'd0, 32'h9);
        found = -1;
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 2'd2, 32'd0);
            if (IRQ === 1'b1) begin
                found = k;
                break;
            end
        end
        check("oneshot2_irq_edge", 32'(found), 32'd4);
        drive(1'b0, 2'd0, 32'd0);
        check("oneshot2_irq_hold", 32'(IRQ), 32'd1);
        check("oneshot2_en_clear", Dout, 32'h8);
        drive(1'b1, 2'd1, 32'd7);
        check("preset_wr_pre_irq", 32'(IRQ), 32'd1);
        drive(1'b0, 2'd2, 32'd0);
        check("preset_wr_irq", 32'(IRQ), 32'd0);
        check("preset_wr_count", Dout, 32'd0);
        drive(1'b0, 2'd1, 32'd0);
        check("preset_rd", Dout, 32'd7);

        // Freeze on En clear, then restart from PRESET.
        drive(1'b1, 2'd1, 32'd10);
        drive(1'b1, 2'd0, 32'h9);
        found = -1;
        for (int k = 0; k < 30; k++) begin
            drive(1'b0, 2'd2, 32'd0);
            if (Dout === 32'd6) begin
                found = k;
                WE   = 1'b1;
                Addr = 2'd0;
                Din  = 32'h8;
                break;
            end
        end
        check("freeze_reach6_edge", 32'(found), 32'd6);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 2'd2, 32'd0);
            check("freeze_count", Dout, 32'd5);
            check("freeze_irq", 32'(IRQ), 32'd0);
        end
        drive(1'b1, 2'd0, 32'h9);
        drive(1'b0, 2'd2, 32'd0);
        check("restart_e0", Dout, 32'd5);
        drive(1'b0, 2'd2, 32'd0);
        check("restart_e1", Dout, 32'd5);
        drive(1'b0, 2'd2, 32'd0);
        check("restart_e2", Dout, 32'd10);
        drive(1'b0, 2'd2, 32'd0);
        check("restart_e3", Dout, 32'd9);
        check("restart_irq", 32'(IRQ), 32'd0);
        do_reset();

        // PRESET = 0 in auto-reload: period of 3, then reset mid-count.
        drive(1'b1, 2'd1, 32'd0);
        drive(1'b1, 2'd0, 32'hB);
        for (int k = 0; k < 11; k++) begin
            drive(1'b0, 2'd2, 32'd0);
            check("p0_irq", 32'(IRQ), ((k > 0) && (k % 3 == 0)) ? 32'd1 : 32'd0);
            check("p0_count", Dout, 32'd0);
        end
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 2'd0, 32'd0);
            check("post_reset_ctrl", Dout, 32'd0);
            check("post_reset_irq", 32'(IRQ), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
